// File: rtl/mem_bus_arbiter_pkg.sv
// mem_arb_pkg: shared definitions for mem_bus_arbiter.
// Provides the access-owner state enum, RAM RW levels, address-mux select
// levels and the width of the fetch starvation counter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC} arb_state_t;
    localparam logic RW_READ     = 1'b1;
    localparam logic RW_WRITE    = 1'b0;
    localparam logic ADDR_SEL_IF = 1'b0;
    localparam logic ADDR_SEL_DM = 1'b1;
    localparam int   STARVE_W    = 4;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: fetch requester, data requester and RAM port signals.
// master: arbiter view (takes requests and RAM read data, drives grants,
//         valids, read data and the RAM address/RW/write-data/select lines).
// slave:  requester/RAM view, directions mirrored.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_valid;
    logic [DATA_W-1:0] dm_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rw;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              addr_sel;
    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
               mem_addr, mem_rw, mem_wdata, addr_sel
    );
    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
               mem_addr, mem_rw, mem_wdata, addr_sel
    );
endinterface

// File: rtl/mem_bus_arbiter_starve_cnt.sv
// mem_arb_starve_cnt: counts consecutive arbitrations a pending fetch lost.
// Ports: clk, rst (sync, active-high); i_if_req fetch pending; i_dm_win data
// requester wins this edge; o_starved count has reached LIMIT.
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_if_req,
    input  logic i_dm_win,
    output logic o_starved
);
    logic [STARVE_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= (i_if_req && i_dm_win) ? ((&r_cnt) ? r_cnt : r_cnt + 1'b1) : '0;
    end
    assign o_starved = r_cnt >= STARVE_W'(LIMIT);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one RAM port between instruction fetch and data
// load/store, one access per cycle, data-over-fetch priority with a fetch
// starvation guard; read data returns registered one cycle after the access.
// Ports: clk, rst (sync, active-high); bus (mem_bus_arbiter_if.master) with
// fetch/data handshakes and the RAM port; with MEM_ARB_PERF_EN defined also
// perf_if_cnt, perf_dm_cnt, perf_stall_cnt (32-bit wrapping counters).
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0] perf_if_cnt,
    output logic [31:0] perf_dm_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    mem_bus_arbiter_if.master bus
);
    arb_state_t        r_state, w_next;
    logic              w_starved, r_we, r_if_valid, r_dm_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_if_rdata, r_dm_rdata;

    mem_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk       (clk),
        .rst       (rst),
        .i_if_req  (bus.if_req),
        .i_dm_win  (w_next == DM_ACC),
        .o_starved (w_starved)
    );

    // A request seen high while its grant is up is the requester's next one
    // (it swaps in new fields on gnt), so back-to-back grants need no gating.
    // The winner's fields are latched so the bus stays put while they change.
    always_comb begin
        w_next        = (bus.if_req && (w_starved || !bus.dm_req)) ? IF_ACC :
                        bus.dm_req ? DM_ACC : IDLE;
        bus.if_gnt    = r_state == IF_ACC;
        bus.dm_gnt    = r_state == DM_ACC;
        bus.addr_sel  = (r_state == DM_ACC) ? ADDR_SEL_DM : ADDR_SEL_IF;
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
        bus.mem_rw    = (r_we && !rst) ? RW_WRITE : RW_READ;
        bus.if_valid  = r_if_valid;
        bus.if_rdata  = r_if_rdata;
        bus.dm_valid  = r_dm_valid;
        bus.dm_rdata  = r_dm_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_state    <= w_next;
            r_addr     <= (w_next == IF_ACC) ? bus.if_addr : (w_next == DM_ACC) ? bus.dm_addr : '0;
            r_wdata    <= (w_next == DM_ACC) ? bus.dm_wdata : '0;
            r_we       <= (w_next == DM_ACC) && bus.dm_we;
            r_if_valid <= r_state == IF_ACC;
            r_dm_valid <= r_state == DM_ACC;
            if (r_state == IF_ACC) r_if_rdata <= bus.mem_rdata;
            if (r_state == DM_ACC) r_dm_rdata <= r_we ? '0 : bus.mem_rdata;
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_cnt    <= '0;
            perf_dm_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_if_cnt    <= perf_if_cnt + 32'(r_state == IF_ACC);
            perf_dm_cnt    <= perf_dm_cnt + 32'(r_state == DM_ACC);
            perf_stall_cnt <= perf_stall_cnt + 32'(bus.if_req && r_state != IF_ACC);
        end
    end
`endif
endmodule
